// File: rtl/adder_arb_pkg.sv
// Shared constants, result-register state type and helpers for the round-robin adder arbiter.
package adder_arb_pkg;

    localparam int ADDER_ARB_WIDTH = 64;
    localparam int ADDER_ARB_NREQ  = 4;
    localparam int ADDER_ARB_ID_W  = $clog2(ADDER_ARB_NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Saturating increment for 32-bit statistics counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_brent_kung.sv
// Brent-Kung parallel-prefix adder; carry-in is folded into bit 0's generate term.
module Brent_kung_64bit #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LOG = $clog2(WIDTH);
    localparam int NST = 2 * LOG - 1;

    logic [WIDTH-1:0] gs [0:NST];
    logic [WIDTH-1:0] ps [0:NST-1];

    assign ps[0] = a ^ b;
    assign gs[0] = {a[WIDTH-1:1] & b[WIDTH-1:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};

    // Levels 1..LOG form the up-sweep tree, the remaining levels fill in the gaps.
    for (genvar k = 1; k <= NST; k++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam bit UP   = (k <= LOG);
            localparam int SPAN = UP ? (1 << (k - 1)) : (1 << (2 * LOG - k - 1));
            localparam bit ACT  = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                     : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
            if (ACT) begin : g_op
                assign gs[k][i] = gs[k-1][i] | (ps[k-1][i] & gs[k-1][i-SPAN]);
                if (k < NST) begin : g_p
                    assign ps[k][i] = ps[k-1][i] & ps[k-1][i-SPAN];
                end
            end else begin : g_pass
                assign gs[k][i] = gs[k-1][i];
                if (k < NST) begin : g_p
                    assign ps[k][i] = ps[k-1][i];
                end
            end
        end
    end

    assign sum  = (a ^ b) ^ {gs[NST][WIDTH-2:0], cin};
    assign cout = gs[NST][WIDTH-1];

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a one-entry result register.
// Optional statistics ports are built when ADDER_ARB_STATS_EN is defined.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = ADDER_ARB_WIDTH,
    parameter int NREQ  = ADDER_ARB_NREQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [$clog2(NREQ)-1:0]  rsp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0]       stat_grants,
    output logic [31:0]              stat_stall
`endif
);

    localparam int IDW = $clog2(NREQ);

    arb_state_e       state_r;
    logic [IDW-1:0]   last_grant_r;
    logic             win_found_s;
    logic [IDW-1:0]   win_idx_s;
    logic             can_accept_s;
    logic             transfer_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             sel_cin_s;
    logic [WIDTH-1:0] add_sum_s;
    logic             add_cout_s;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = (int'(last_grant_r) + 1 + k) % NREQ;
            if (!win_found_s && req_valid[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDW'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign can_accept_s = (state_r == EMPTY) || rsp_ready;
    assign req_ready    = (win_found_s && can_accept_s)
                          ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx_s) : {NREQ{1'b0}};
    assign transfer_s   = |req_ready;

    assign sel_a_s   = req_a[int'(win_idx_s)*WIDTH +: WIDTH];
    assign sel_b_s   = req_b[int'(win_idx_s)*WIDTH +: WIDTH];
    assign sel_cin_s = req_cin[win_idx_s];

    Brent_kung_64bit #(.WIDTH(WIDTH)) u_adder (
        .a    (sel_a_s),
        .b    (sel_b_s),
        .cin  (sel_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Result-register FSM; a transfer while FULL replaces the result being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= EMPTY;
            rsp_sum      <= '0;
            rsp_cout     <= 1'b0;
            rsp_id       <= '0;
            last_grant_r <= IDW'(NREQ - 1);
        end else begin
            case (state_r)
                EMPTY:   state_r <= transfer_s ? FULL : EMPTY;
                FULL:    state_r <= (transfer_s || !rsp_ready) ? FULL : EMPTY;
                default: state_r <= EMPTY;
            endcase
            if (transfer_s) begin
                rsp_sum      <= add_sum_s;
                rsp_cout     <= add_cout_s;
                rsp_id       <= win_idx_s;
                last_grant_r <= win_idx_s;
            end else begin
                rsp_sum      <= rsp_sum;
                rsp_cout     <= rsp_cout;
                rsp_id       <= rsp_id;
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign rsp_valid = (state_r == FULL);

`ifdef ADDER_ARB_STATS_EN
    logic [31:0] grant_cnt_r [NREQ];

    // Saturating per-requester transfer counters and backpressure stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_r[i] <= 32'd0;
            end
            stat_stall <= 32'd0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grant_cnt_r[i] <= sat_inc32(grant_cnt_r[i]);
                end else begin
                    grant_cnt_r[i] <= grant_cnt_r[i];
                end
            end
            if ((state_r == FULL) && !rsp_ready) begin
                stat_stall <= sat_inc32(stat_stall);
            end else begin
                stat_stall <= stat_stall;
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        assign stat_grants[i*32 +: 32] = grant_cnt_r[i];
    end
`endif

endmodule

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/sum width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  NREQ x WIDTH  operand a per requester.
REQ-008 SHALL have port req_b  input  NREQ x WIDTH  operand b per requester.
REQ-009 SHALL have port req_cin  input  NREQ  carry-in per requester.
REQ-010 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-011 SHALL have port rsp_ready  input  1  downstream accepts result.
REQ-012 SHALL have port rsp_sum  output  WIDTH  registered sum.
REQ-013 SHALL have port rsp_cout  output  1  registered carry-out.
REQ-014 SHALL have port rsp_id  output  $clog2(NREQ)  index of requester owning the result.

Function
REQ-015 SHALL share one combinational WIDTH-bit adder among all requesters; result = a + b + cin, carry-out in rsp_cout, modulo 2^WIDTH.
REQ-016 SHALL keep a one-entry result register with FSM states EMPTY and FULL.
REQ-017 SHALL assert req_ready[i] combinationally only when req_valid[i]=1, i is the round-robin winner, and (state EMPTY or (FULL and rsp_ready=1)).
REQ-018 SHALL transfer a request when req_valid[i] && req_ready[i]; operands, cin and id are captured at that edge; rsp_valid rises the following cycle (latency 1).
REQ-019 SHALL transition EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready without transfer; stay FULL (new result replaces drained one) on simultaneous rsp_ready and transfer.
REQ-020 SHALL hold rsp_sum, rsp_cout, rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL arbitrate round-robin: search starts at (last_grant+1) mod NREQ, wrapping; pointer updates only on a transfer.
REQ-022 SHALL never grant a requester whose req_valid=0; with no valid request, req_ready=0 and pointer unchanged.
REQ-023 SHALL sustain one transfer per cycle when rsp_ready is held 1.
REQ-024 SHALL let requesters keep req_valid high with stable operands until granted (no drop required by arbiter).

Reset
REQ-025 SHALL, on rst_n low (asynchronous), force state EMPTY, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=NREQ-1 (requester 0 highest priority first).
REQ-026 SHALL discard any held result on reset mid-operation; first post-reset transfer occurs no earlier than first rising edge with rst_n high.

Configuration
REQ-027 SHALL, with ADDER_ARB_STATS_EN defined, add output stat_grants (NREQ x 32, saturating per-requester transfer counters, reset 0) and output stat_stall (32-bit saturating count of cycles FULL with rsp_ready=0, reset 0).
REQ-028 SHALL, without ADDER_ARB_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place WIDTH/NREQ defaults, ID width constant and the state enum (EMPTY, FULL) in shared package adder_arb_pkg.
REQ-030 SHALL instantiate the existing Brent_kung_64bit as its single sub-module for the add; muxing, arbitration and result register stay in adder_rr_arbiter.

Verification
REQ-031 Reset: rst_n=0 mid-FULL -> rsp_valid=0, rsp_sum=0, rsp_id=0 immediately, without clock edge.
REQ-032 Single request: req_valid=0001, a=255, b=255, cin=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=511, rsp_cout=0, rsp_id=0.
REQ-033 All valid, rsp_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles; one rsp per cycle.
REQ-034 Backpressure: rsp_ready=0 with FULL -> req_ready=0000, rsp outputs stable for 5 cycles; rsp_ready=1 -> same cycle grant of next RR winner.
REQ-035 Carry boundary: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> rsp_sum=0, rsp_cout=1; 100 random operands checked against a+b+cin reference model.
REQ-036 With ADDER_ARB_STATS_EN: 10 transfers from requester 2, 3 stall cycles -> stat_grants[2]=10, others 0, stat_stall=3.
